// File: rtl/hazard_scoreboard_if.sv
// ID-side hazard bundle: decode fields and branch in, stall/flush/issue out.
// master = ID stage driver, slave = hazard_scoreboard.
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic              id_rs_use_i;
  logic              id_rt_use_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              id_regwrite_i;
  logic [1:0]        id_class_i;
  logic              branch_taken_i;
  logic              pc_write_o;
  logic              ifid_write_o;
  logic              ifid_flush_o;
  logic              idex_flush_o;
  logic              issue_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;

  modport master (
    output id_valid_i, id_rs_i, id_rt_i, id_rs_use_i, id_rt_use_i,
    output id_rd_i, id_regwrite_i, id_class_i, branch_taken_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o,
    input  issue_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs_i, id_rt_i, id_rs_use_i, id_rt_use_i,
    input  id_rd_i, id_regwrite_i, id_class_i, branch_taken_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o,
    output issue_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Countdown scoreboard for RAW/WAW on long-latency writes; drives stall/flush/issue.
// Ports: clk_i, rst_i (sync, high), hz (slave). `HAZ_PERF_CNT_EN adds perf counters.
module hazard_scoreboard #(
  parameter int REG_NUM = 32,
  parameter int REG_AW  = 5,
  parameter int MEM_LAT = 1,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  hazard_scoreboard_if.slave hz
);
  localparam int MAXL  = (MEM_LAT > MUL_LAT) ? MEM_LAT : MUL_LAT;
  localparam int LAT_W = $clog2(MAXL + 1);

  logic [LAT_W-1:0] cnt_q [REG_NUM];
  logic [LAT_W-1:0] cnt_d [REG_NUM];
  logic [LAT_W-1:0] lat;
  logic rs_busy, rt_busy, waw, raw;
  logic stall, issue, load;

  always_comb begin
    lat = '0;
    case (hz.id_class_i)
      2'd1:    lat = LAT_W'(MEM_LAT);
      2'd2:    lat = LAT_W'(MUL_LAT);
      default: lat = '0;
    endcase
  end

  assign rs_busy = hz.id_rs_use_i && (hz.id_rs_i != '0)
                && (cnt_q[hz.id_rs_i] != '0);
  assign rt_busy = hz.id_rt_use_i && (hz.id_rt_i != '0)
                && (cnt_q[hz.id_rt_i] != '0);
  assign raw = rs_busy || rt_busy;
  assign waw = hz.id_regwrite_i && (hz.id_rd_i != '0)
            && (cnt_q[hz.id_rd_i] != '0);

  // a taken branch kills the ID instruction, so it never stalls
  assign stall = hz.id_valid_i && !hz.branch_taken_i && (raw || waw);
  assign issue = hz.id_valid_i && !hz.branch_taken_i && !stall;
  assign load  = issue && hz.id_regwrite_i && (hz.id_rd_i != '0);
  assign hz.issue_o = issue;

  always_comb begin
    hz.pc_write_o   = 1'b1;
    hz.ifid_write_o = 1'b1;
    hz.ifid_flush_o = 1'b0;
    hz.idex_flush_o = 1'b0;
    unique case (1'b1)
      hz.branch_taken_i: begin
        hz.ifid_flush_o = 1'b1;
        hz.idex_flush_o = 1'b1;
      end
      stall: begin
        hz.pc_write_o   = 1'b0;
        hz.ifid_write_o = 1'b0;
        hz.idex_flush_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d[0] = '0;
    for (int r = 1; r < REG_NUM; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
      // fresh issue overrides the decrement on its own entry
      if (load && (r == int'(hz.id_rd_i)))
        cnt_d[r] = lat;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < REG_NUM; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < REG_NUM; r++) cnt_q[r] <= cnt_d[r];
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (hz.branch_taken_i && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign hz.stall_cnt_o = stall_cnt_q;
  assign hz.flush_cnt_o = flush_cnt_q;
`else
  assign hz.stall_cnt_o = '0;
  assign hz.flush_cnt_o = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed test-plan steps then random traffic,
// checked against a ready-time reference model.
module tb_hazard_scoreboard;
  localparam int MEM_LAT = 1;
  localparam int MUL_LAT = 4;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_AW(5), .CNT_W(CNT_W)) hz ();

  hazard_scoreboard #(
    .REG_NUM(32), .REG_AW(5), .MEM_LAT(MEM_LAT),
    .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .hz(hz.slave)
  );

  // model: cycle at which each register's result becomes usable
  longint now = 0;
  longint ready [32];
  longint m_scnt = 0;
  longint m_fcnt = 0;
  logic   last_issue;
  logic   last_stall;

  function automatic int lat_of(input logic [1:0] c);
    if (c == 2'd1) return MEM_LAT;
    if (c == 2'd2) return MUL_LAT;
    return 0;
  endfunction

  function automatic bit busy(input logic [4:0] r);
    return (r != 0) && (now < ready[r]);
  endfunction

  task automatic drive(input bit v, input int rs, input bit rsu,
                       input int rt, input bit rtu, input int rd,
                       input bit rw, input int cls, input bit br);
    hz.id_valid_i     = v;
    hz.id_rs_i        = 5'(rs);
    hz.id_rs_use_i    = rsu;
    hz.id_rt_i        = 5'(rt);
    hz.id_rt_use_i    = rtu;
    hz.id_rd_i        = 5'(rd);
    hz.id_regwrite_i  = rw;
    hz.id_class_i     = 2'(cls);
    hz.branch_taken_i = br;
  endtask

  // one cycle: check at negedge, advance the model at the posedge
  task automatic cyc(input string tag);
    bit raw, waw, st, is;
    logic [4:0] exp_o, obs_o;
    logic [2*CNT_W-1:0] exp_c, obs_c;
    @(negedge clk);
    raw = (hz.id_rs_use_i && busy(hz.id_rs_i))
       || (hz.id_rt_use_i && busy(hz.id_rt_i));
    waw = hz.id_regwrite_i && busy(hz.id_rd_i);
    st  = hz.id_valid_i && !hz.branch_taken_i && (raw || waw);
    is  = hz.id_valid_i && !hz.branch_taken_i && !st;
    exp_o = {!st, !st, hz.branch_taken_i,
             hz.branch_taken_i || st, is};
    obs_o = {hz.pc_write_o, hz.ifid_write_o, hz.ifid_flush_o,
             hz.idex_flush_o, hz.issue_o};
`ifdef HAZ_PERF_CNT_EN
    exp_c = {CNT_W'(m_scnt), CNT_W'(m_fcnt)};
`else
    exp_c = '0;
`endif
    obs_c = {hz.stall_cnt_o, hz.flush_cnt_o};
    checks++;
    assert (obs_o === exp_o) else begin
      failures++;
      $error("FAIL %s ctl obs=%b exp=%b t=%0d", tag, obs_o, exp_o, now);
    end
    checks++;
    assert (obs_c === exp_c) else begin
      failures++;
      $error("FAIL %s cnt obs=%h exp=%h t=%0d", tag, obs_c, exp_c, now);
    end
    last_issue = hz.issue_o;
    last_stall = st;
    @(posedge clk);
    if (rst) begin
      foreach (ready[i]) ready[i] = 0;
      m_scnt = 0;
      m_fcnt = 0;
    end else begin
      if (is && hz.id_regwrite_i && hz.id_rd_i != 0)
        ready[hz.id_rd_i] = now + 1 + lat_of(hz.id_class_i);
      if (st && m_scnt < (2**CNT_W - 1)) m_scnt++;
      if (hz.branch_taken_i && m_fcnt < (2**CNT_W - 1)) m_fcnt++;
    end
    now++;
    #1;
  endtask

  task automatic expect_val(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    foreach (ready[i]) ready[i] = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    cyc("reset0");
    cyc("reset1");
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("idle");

    // load-use, single bubble
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
    cyc("ld5");
    drive(1, 5, 1, 0, 0, 6, 1, 0, 0);
    n = 0;
    cyc("use5");
    while (!last_issue && n < 10) begin cyc("use5w"); n++; end
    expect_val("ld_bubbles", n, 1);

    // mul then rt consumer
    drive(1, 0, 0, 0, 0, 8, 1, 2, 0);
    cyc("mul8");
    drive(1, 0, 0, 8, 1, 9, 1, 0, 0);
    n = 0;
    cyc("use8");
    while (!last_issue && n < 10) begin cyc("use8w"); n++; end
    expect_val("mul_bubbles", n, 4);

    // WAW: ALU rd=8 behind MUL rd=8
    drive(1, 0, 0, 0, 0, 8, 1, 2, 0);
    cyc("mul8b");
    drive(1, 0, 0, 0, 0, 8, 1, 0, 0);
    n = 0;
    cyc("waw8");
    while (!last_issue && n < 10) begin cyc("waw8w"); n++; end
    expect_val("waw_bubbles", n, 4);
    drive(1, 8, 1, 0, 0, 1, 1, 0, 0);
    cyc("after_waw");

    // r0 never tracked
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc("ld0");
    drive(1, 0, 1, 0, 1, 2, 1, 0, 0);
    cyc("use0");

    // branch beats stall
    drive(1, 0, 0, 0, 0, 4, 1, 2, 0);
    cyc("mul4");
    drive(1, 4, 1, 4, 1, 7, 1, 0, 1);
    cyc("br_over_stall");
    drive(1, 4, 1, 4, 1, 7, 1, 0, 0);
    cyc("still_stall");
    expect_val("still_stall_flag", int'(last_stall), 1);
    drive(0, 4, 1, 4, 1, 7, 1, 0, 0);
    cyc("invalid");

    // reset mid-stall
    drive(1, 0, 0, 0, 0, 3, 1, 2, 0);
    cyc("mul3");
    drive(1, 3, 1, 0, 0, 10, 1, 0, 0);
    cyc("use3a");
    rst = 1'b1;
    cyc("rst_mid");
    rst = 1'b0;
    cyc("use3_post");
    expect_val("post_rst_issue", int'(last_issue), 1);

    // random traffic over a small register window
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 60) == 0);
      drive($urandom_range(0, 7) != 0,
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3), $urandom_range(0, 7) == 0);
      cyc("rand");
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
